pwr_seq_multi_rail: RTL

- Parametrised master power sequencer for the PDB CPLD.
- Brings up NUM_RAILS enable/power-good rail pairs strictly in index order, with per-step power-good timeout and dwell.
- Shuts rails down in reverse order when the request drops or a leak is detected; performs an immediate latched shutdown on a fault.
- Sits between the board-level request/leak/fault inputs and the rail enable pins; exports state for the 4-bit state logger.

---
 rtl/pwr_seq_pkg.sv | 32 +++
 rtl/seq_dly_cnt.sv | 36 +++
 rtl/pwr_seq_multi_rail.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pwr_seq_pkg.sv
// rtl/pwr_seq_pkg.sv - shared state codes, delay defaults and helpers for the rail sequencer
package pwr_seq_pkg;

    localparam int MAX_RAILS  = 8;
    localparam int RAIL_IDX_W = 3;

    localparam int DEF_STBY_DLY_MS   = 5000;
    localparam int DEF_PG_TIMEOUT_MS = 100;
    localparam int DEF_ON_DWELL_MS   = 10;
    localparam int DEF_OFF_DLY_MS    = 10;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_STBY    = 4'd1,
        ST_OFF     = 4'd2,
        ST_RAMP_UP = 4'd3,
        ST_DWELL   = 4'd4,
        ST_ON      = 4'd5,
        ST_RAMP_DN = 4'd6,
        ST_LEAK    = 4'd7,
        ST_FAULT   = 4'd8
    } seq_state_e;

    // Lowest set bit wins so the logger reports the earliest rail in the chain.
    function automatic logic [RAIL_IDX_W-1:0] lowest_set(input logic [MAX_RAILS-1:0] v);
        lowest_set = '0;
        for (int i = MAX_RAILS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = RAIL_IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/seq_dly_cnt.sv
// rtl/seq_dly_cnt.sv - 1 ms tick counter with clear and compare-equal expiry
module seq_dly_cnt
#(
    parameter int DLY_W = 16
)(
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             clr_i,
    input  logic             tick_i,
    input  logic [DLY_W-1:0] cmp_i,
    output logic             expired_o
);

    logic [DLY_W-1:0] cnt_q, cnt_d;

    // Saturates so a long wait in an untimed state never wraps into a false match.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + DLY_W'(1);
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == cmp_i);

endmodule

// File: rtl/pwr_seq_multi_rail.sv
// rtl/pwr_seq_multi_rail.sv - ordered multi-rail power sequencer with timeout, leak and fault handling
module pwr_seq_multi_rail
    import pwr_seq_pkg::*;
#(
    parameter int NUM_RAILS     = 4,
    parameter int DLY_W         = 16,
    parameter int STBY_DLY_MS   = DEF_STBY_DLY_MS,
    parameter int PG_TIMEOUT_MS = DEF_PG_TIMEOUT_MS,
    parameter int ON_DWELL_MS   = DEF_ON_DWELL_MS,
    parameter int OFF_DLY_MS    = DEF_OFF_DLY_MS
)(
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iTick_1ms,
    input  logic                  iAux_PG,
    input  logic                  iPwr_Req,
    input  logic                  iLeak_N,
    input  logic                  iFault_N,
    input  logic                  iLatch_Clear,
    input  logic [NUM_RAILS-1:0]  iRail_PG,
    output logic [NUM_RAILS-1:0]  oRail_EN,
    output logic                  oPwr_Ok,
    output logic                  oFault,
    output logic [2:0]            oFault_Rail,
    output logic [3:0]            oState
);

    localparam logic [RAIL_IDX_W-1:0] LAST_IDX = RAIL_IDX_W'(NUM_RAILS - 1);

    seq_state_e               state_q, state_d;
    logic [RAIL_IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_RAILS-1:0]     en_q, en_d;
    logic                     fault_q, fault_d;
    logic [RAIL_IDX_W-1:0]    fault_rail_q, fault_rail_d;
    logic                     leak_cause_q, leak_cause_d;
    logic                     pwr_ok_q, pwr_ok_d;

    logic [NUM_RAILS-1:0]     cur_mask, nxt_mask, prv_mask, pg_lost;
    logic [DLY_W-1:0]         tmr_cmp;
    logic                     tmr_clr, tmr_exp;

    assign cur_mask = NUM_RAILS'(1) << idx_q;
    assign nxt_mask = NUM_RAILS'(1) << (idx_q + RAIL_IDX_W'(1));
    assign prv_mask = NUM_RAILS'(1) << (idx_q - RAIL_IDX_W'(1));

    // The rail currently ramping has no PG yet, so it is excluded from loss detection.
    assign pg_lost = en_q & ~iRail_PG & ((state_q == ST_RAMP_UP) ? ~cur_mask : '1);

    always_comb begin
        tmr_cmp = '1;
        case (state_q)
            ST_STBY:    tmr_cmp = DLY_W'(STBY_DLY_MS);
            ST_RAMP_UP: tmr_cmp = DLY_W'(PG_TIMEOUT_MS);
            ST_DWELL:   tmr_cmp = DLY_W'(ON_DWELL_MS);
            ST_RAMP_DN: tmr_cmp = DLY_W'(OFF_DLY_MS);
            default:    tmr_cmp = '1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        en_d         = en_q;
        fault_d      = fault_q;
        fault_rail_d = fault_rail_q;
        leak_cause_d = leak_cause_q;

        if (!iAux_PG) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            en_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    en_d    = '0;
                    state_d = ST_STBY;
                end
                ST_STBY: begin
                    if (tmr_exp) state_d = ST_OFF;
                end
                ST_OFF: begin
                    en_d = '0;
                    if (iPwr_Req && iLeak_N && iFault_N) begin
                        state_d = ST_RAMP_UP;
                        idx_d   = '0;
                        en_d    = NUM_RAILS'(1);
                    end
                end
                ST_RAMP_UP, ST_DWELL, ST_ON: begin
                    if (!iFault_N || (|pg_lost)) begin
                        state_d = ST_FAULT;
                        en_d    = '0;
                        fault_d = 1'b1;
                        if (|pg_lost) fault_rail_d = lowest_set(MAX_RAILS'(pg_lost));
                    end else if (!iLeak_N || !iPwr_Req) begin
                        state_d      = ST_RAMP_DN;
                        en_d         = en_q & ~cur_mask;
                        leak_cause_d = !iLeak_N;
                    end else if (state_q == ST_RAMP_UP) begin
                        if (|(iRail_PG & cur_mask)) begin
                            state_d = ST_DWELL;
                        end else if (tmr_exp) begin
                            state_d      = ST_FAULT;
                            en_d         = '0;
                            fault_d      = 1'b1;
                            fault_rail_d = idx_q;
                        end
                    end else if ((state_q == ST_DWELL) && tmr_exp) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_ON;
                        end else begin
                            state_d = ST_RAMP_UP;
                            idx_d   = idx_q + RAIL_IDX_W'(1);
                            en_d    = en_q | nxt_mask;
                        end
                    end
                end
                ST_RAMP_DN: begin
                    if (tmr_exp) begin
                        if (idx_q == '0) begin
                            state_d = leak_cause_q ? ST_LEAK : ST_OFF;
                        end else begin
                            idx_d = idx_q - RAIL_IDX_W'(1);
                            en_d  = en_q & ~prv_mask;
                        end
                    end
                end
                ST_LEAK: begin
                    en_d = '0;
                    if (iLeak_N) state_d = ST_OFF;
                end
                ST_FAULT: begin
                    en_d = '0;
                    if (iLatch_Clear && iFault_N && iLeak_N) begin
                        state_d = ST_OFF;
                        fault_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    en_d    = '0;
                end
            endcase
        end
    end

    assign tmr_clr  = (state_d != state_q) || (idx_d != idx_q);
    assign pwr_ok_d = (state_q == ST_ON) && (state_d == ST_ON);

    seq_dly_cnt #(
        .DLY_W (DLY_W)
    ) u_dly (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .clr_i     (tmr_clr),
        .tick_i    (iTick_1ms),
        .cmp_i     (tmr_cmp),
        .expired_o (tmr_exp)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            en_q         <= '0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
            leak_cause_q <= 1'b0;
            pwr_ok_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            en_q         <= en_d;
            fault_q      <= fault_d;
            fault_rail_q <= fault_rail_d;
            leak_cause_q <= leak_cause_d;
            pwr_ok_q     <= pwr_ok_d;
        end
    end

    assign oRail_EN    = en_q;
    assign oPwr_Ok     = pwr_ok_q;
    assign oFault      = fault_q;
    assign oFault_Rail = fault_rail_q;
    assign oState      = state_q;

endmodule
